// File: rtl/bip_data_memory.sv
// bip_data_memory
// ---------------------------------------------------------------------------
// Single-port synchronous data memory. It zero-fills itself after reset and
// then serves one read and/or one write per clock on a shared address.
//
// Parameters
//   DATA_W  data word width
//   ADDR_W  address width
//   DEPTH   number of implemented words (1 .. 2**ADDR_W)
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RESET      synchronous, active-low reset
//   RD         read request (sampled each edge)
//   WR         write request (sampled each edge)
//   ADDR       word address shared by RD and WR
//   IN_DATA    write data
//   OUT_DATA   registered read data, holds when no read is accepted
//   OUT_VALID  one-cycle pulse per accepted read
//   BUSY       high while resetting or zero-filling; requests are ignored
//   ADDR_ERR   one-cycle pulse for an accepted request with ADDR >= DEPTH
//
// Build option
//   DMEM_WR_FWD_EN  when defined, a read and write in the same cycle return
//                   the new write data; otherwise the pre-write contents.
// ---------------------------------------------------------------------------
module bip_data_memory #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2048
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              RD,
   input  logic              WR,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   output logic              BUSY,
   output logic              ADDR_ERR
);

   // Index width covers exactly the implemented words; never wider than ADDR.
   localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      RST   = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              clr_go;
   logic              wr_go;
   logic [DATA_W-1:0] rd_word;

   // Compare with one extra bit so DEPTH == 2**ADDR_W is representable.
   assign in_range = ({1'b0, ADDR} < DEPTH_L);
   assign idx      = ADDR[IDX_W-1:0];

   // RESET low has priority: no clear write and no user write on that edge.
   assign clr_go = RESET && (state == CLEAR);
   assign wr_go  = RESET && (state == READY) && WR && in_range;

   // Out-of-range reads return zero rather than an aliased word.
   always_comb begin
      rd_word = '0;
      if (in_range) begin
`ifdef DMEM_WR_FWD_EN
         rd_word = WR ? IN_DATA : mem[idx];
`else
         rd_word = mem[idx];
`endif
      end
   end

   // Storage: zero-fill sweep during CLEAR, user writes only in READY.
   always_ff @(posedge CLK) begin
      if (clr_go) begin
         mem[clr_cnt] <= '0;
      end else if (wr_go) begin
         mem[idx] <= IN_DATA;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state     <= RST;
         clr_cnt   <= '0;
         OUT_DATA  <= '0;
         OUT_VALID <= 1'b0;
         ADDR_ERR  <= 1'b0;
         BUSY      <= 1'b1;
      end else begin
         case (state)
            RST: begin
               state     <= CLEAR;
               clr_cnt   <= '0;
               BUSY      <= 1'b1;
               OUT_VALID <= 1'b0;
               ADDR_ERR  <= 1'b0;
            end
            CLEAR: begin
               OUT_VALID <= 1'b0;
               ADDR_ERR  <= 1'b0;
               if (clr_cnt == LAST_IDX) begin
                  state <= READY;
                  BUSY  <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + IDX_W'(1);
               end
            end
            READY: begin
               BUSY      <= 1'b0;
               OUT_VALID <= RD;
               // One pulse per edge even when RD and WR both miss.
               ADDR_ERR  <= (RD || WR) && !in_range;
               if (RD) begin
                  OUT_DATA <= rd_word;
               end
            end
            default: begin
               state     <= RST;
               clr_cnt   <= '0;
               BUSY      <= 1'b1;
               OUT_VALID <= 1'b0;
               ADDR_ERR  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bip_data_memory.sv
// tb_bip_data_memory
// Drives a default-size instance (DEPTH 2048) and a short instance
// (DEPTH 1000) from the same stimulus. Expected read/error responses are
// queued at issue time and popped by a monitor that watches the outputs.
`timescale 1ns/1ps
module tb_bip_data_memory;

`ifdef DMEM_WR_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int DA = 2048;
   localparam int DB = 1000;

   logic        clk;
   logic        reset;
   logic        rd;
   logic        wr;
   logic [10:0] addr;
   logic [15:0] in_data;
   logic [15:0] out_a, out_b;
   logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b;

   bip_data_memory #(.DATA_W(16), .ADDR_W(11), .DEPTH(DA)) dut_a (
      .CLK(clk), .RESET(reset), .RD(rd), .WR(wr), .ADDR(addr), .IN_DATA(in_data),
      .OUT_DATA(out_a), .OUT_VALID(vld_a), .BUSY(busy_a), .ADDR_ERR(err_a));

   bip_data_memory #(.DATA_W(16), .ADDR_W(11), .DEPTH(DB)) dut_b (
      .CLK(clk), .RESET(reset), .RD(rd), .WR(wr), .ADDR(addr), .IN_DATA(in_data),
      .OUT_DATA(out_b), .OUT_VALID(vld_b), .BUSY(busy_b), .ADDR_ERR(err_b));

   typedef struct {
      int          edge_no;
      logic [15:0] data;
      logic        err;
   } rd_t;

   rd_t         qa[$];
   rd_t         qb[$];
   int          ea[$];
   int          eb[$];
   logic [15:0] ma [DA];
   logic [15:0] mb [DB];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: word store per instance, responses timed one edge out.
   task automatic op(input bit r, input bit w, input int a, input int d, input bit track);
      rd_t x;
      bit  inb;
      @(negedge clk);
      rd      = r;
      wr      = w;
      addr    = 11'(a);
      in_data = 16'(d);
      if (track) begin
         inb = (a < DB);
         if (r) begin
            x.edge_no = cyc + 1;
            x.err     = 1'b0;
            x.data    = (w && FWD) ? in_data : ma[a];
            qa.push_back(x);
            x.err     = !inb;
            x.data    = !inb ? 16'h0 : ((w && FWD) ? in_data : mb[a]);
            qb.push_back(x);
         end else if (w && !inb) begin
            eb.push_back(cyc + 1);
         end
         if (w) ma[a] = in_data;
         if (w && inb) mb[a] = in_data;
      end
      @(posedge clk);
   endtask

   task automatic zero_models();
      for (int i = 0; i < DA; i++) ma[i] = 16'h0;
      for (int i = 0; i < DB; i++) mb[i] = 16'h0;
   endtask

   task automatic count_busy(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk);
         #1;
         if (busy_a) na++;
         if (busy_b) nb++;
         if (!busy_a && !busy_b) break;
      end
   endtask

   task automatic mon(input int k, input logic v, input logic [15:0] d, input logic e);
      rd_t r;
      int  n_r, n_e, e_edge;
      string p;
      p   = (k == 0) ? "a" : "b";
      n_r = (k == 0) ? qa.size() : qb.size();
      n_e = (k == 0) ? ea.size() : eb.size();
      if (v === 1'b1) begin
         if (n_r == 0) chk({p, "_spurious_valid"}, 32'(v), 32'd0);
         else begin
            if (k == 0) r = qa.pop_front(); else r = qb.pop_front();
            chk({p, "_rd_latency"}, cyc, r.edge_no);
            chk({p, "_rd_data"}, 32'(d), 32'(r.data));
            chk({p, "_rd_addr_err"}, 32'(e), 32'(r.err));
         end
      end else if (e === 1'b1) begin
         if (n_e == 0) chk({p, "_spurious_addr_err"}, 32'(e), 32'd0);
         else begin
            if (k == 0) e_edge = ea.pop_front(); else e_edge = eb.pop_front();
            chk({p, "_addr_err_latency"}, cyc, e_edge);
         end
      end else begin
         if (n_r > 0) begin
            if (k == 0) r = qa[0]; else r = qb[0];
            if (r.edge_no < cyc) begin
               chk({p, "_missing_valid"}, 32'(v), 32'd1);
               if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
         end
         if (n_e > 0) begin
            if (k == 0) e_edge = ea[0]; else e_edge = eb[0];
            if (e_edge < cyc) begin
               chk({p, "_missing_addr_err"}, 32'(e), 32'd1);
               if (k == 0) void'(ea.pop_front()); else void'(eb.pop_front());
            end
         end
      end
   endtask

   always begin
      @(posedge clk);
      cyc++;
      #1;
      mon(0, vld_a, out_a, err_a);
      mon(1, vld_b, out_b, err_b);
   end

   task automatic drain_check();
      op(0, 0, 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_a_drained", qa.size() + ea.size(), 0);
      chk("queue_b_drained", qb.size() + eb.size(), 0);
   endtask

   initial begin
      int na, nb, pick, a;
      reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; in_data = '0;
      zero_models();

      // Reset held for three edges.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_data", 32'(out_a), 0);
      chk("reset_out_valid", 32'(vld_a), 0);
      chk("reset_addr_err", 32'(err_a), 0);
      chk("reset_busy_a", 32'(busy_a), 1);
      chk("reset_busy_b", 32'(busy_b), 1);

      @(negedge clk);
      reset = 1'b1;
      count_busy(na, nb);
      chk("clear_busy_edges_a", na, DA);
      chk("clear_busy_edges_b", nb, DB);
      chk("ready_busy_low", 32'(busy_a), 0);

      // Freshly cleared word.
      op(1, 0, 5, 0, 1'b1);
      #1 chk("read5_after_clear", 32'(out_a), 0);

      // Write then read with one-cycle latency.
      op(0, 1, 1, 2, 1'b1);
      op(1, 0, 1, 0, 1'b1);
      #1;
      chk("rd1_valid", 32'(vld_a), 1);
      chk("rd1_data", 32'(out_a), 2);
      op(0, 0, 0, 0, 1'b1);
      #1 chk("rd1_valid_drop", 32'(vld_a), 0);
      chk("rd1_data_hold", 32'(out_a), 2);

      // Same-address read and write.
      op(0, 1, 2, 4, 1'b1);
      op(1, 1, 2, 9, 1'b1);
      #1 chk("same_addr_rw", 32'(out_a), FWD ? 32'd9 : 32'd4);
      op(1, 0, 2, 0, 1'b1);
      #1 chk("same_addr_later", 32'(out_a), 9);

      // Out-of-range accesses on the short instance.
      op(0, 1, 476, 16'h55, 1'b1);
      op(0, 1, 1500, 7, 1'b1);
      #1;
      chk("oor_wr_err_b", 32'(err_b), 1);
      chk("oor_wr_err_a", 32'(err_a), 0);
      op(1, 0, 1500, 0, 1'b1);
      #1;
      chk("oor_rd_data_b", 32'(out_b), 0);
      chk("oor_rd_err_b", 32'(err_b), 1);
      chk("oor_rd_data_a", 32'(out_a), 7);
      op(1, 0, 476, 0, 1'b1);
      #1;
      chk("alias_476_b", 32'(out_b), 32'h55);
      chk("alias_err_drop_b", 32'(err_b), 0);
      op(1, 1, 1700, 3, 1'b1);
      #1 chk("oor_rdwr_err_b", 32'(err_b), 1);

      // Streaming reads.
      for (int i = 0; i < 4; i++) op(0, 1, i, 10 + i, 1'b1);
      for (int i = 0; i < 4; i++) begin
         op(1, 0, i, 0, 1'b1);
         #1;
         chk($sformatf("stream%0d_valid", i), 32'(vld_a), 1);
         chk($sformatf("stream%0d_data", i), 32'(out_a), 10 + i);
      end

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         pick = $urandom_range(0, 2);
         if (pick == 0)      a = $urandom_range(0, 15);
         else if (pick == 1) a = $urandom_range(990, 1030);
         else                a = $urandom_range(0, 2047);
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 65535)), 1'b1);
      end
      drain_check();

      // Reset in the middle of the zero-fill, then random requests while busy.
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      na = 0;
      for (int i = 0; i < 5000 && na < 100; i++) begin
         @(posedge clk);
         #1;
         if (busy_a) na++;
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      fork
         count_busy(na, nb);
         begin
            for (int i = 0; i < 950; i++)
               op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2047)), int'($urandom_range(0, 65535)), 1'b0);
            op(0, 0, 0, 0, 1'b0);
         end
      join
      chk("abort_busy_edges_a", na, DA);
      chk("abort_busy_edges_b", nb, DB);
      zero_models();

      // Every location must read zero.
      for (int i = 0; i < DA; i++) op(1, 0, i, 0, 1'b1);
      drain_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bip_data_memory.md
BIP_DATA_MEMORY -- requirements
Module: bip_data_memory

Interface
- REQ-001 The block SHALL expose parameter DATA_W, default 16: data word width in bits.
- REQ-002 The block SHALL expose parameter ADDR_W, default 11: address width in bits.
- REQ-003 The block SHALL expose parameter DEPTH, default 2048: number of implemented words, 1 <= DEPTH <= 2^ADDR_W.
- REQ-004 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
- REQ-005 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-low.
- REQ-006 The block SHALL have port RD, input, 1 bit: read request, sampled each edge.
- REQ-007 The block SHALL have port WR, input, 1 bit: write request, sampled each edge.
- REQ-008 The block SHALL have port ADDR, input, ADDR_W bits: word address for RD and WR.
- REQ-009 The block SHALL have port IN_DATA, input, DATA_W bits: write data.
- REQ-010 The block SHALL have port OUT_DATA, output, DATA_W bits: registered read data.
- REQ-011 The block SHALL have port OUT_VALID, output, 1 bit: one-cycle pulse marking new OUT_DATA.
- REQ-012 The block SHALL have port BUSY, output, 1 bit: high while the block is resetting or clearing; requests are ignored.
- REQ-013 The block SHALL have port ADDR_ERR, output, 1 bit: one-cycle pulse for an accepted request with ADDR >= DEPTH.

Function
- REQ-014 The block SHALL implement the FSM states RST, CLEAR and READY.
- REQ-015 RST SHALL be entered on any edge with RESET=0, then go to CLEAR on the first edge with RESET=1.
- REQ-016 CLEAR SHALL write zero to one location per edge, from address 0 upward, and go to READY after address DEPTH-1 is written, for DEPTH edges total.
- REQ-017 BUSY SHALL be 1 in RST and CLEAR and 0 only in READY.
- REQ-018 In RST and CLEAR, RD and WR SHALL be ignored: no write, no OUT_VALID, no ADDR_ERR.
- REQ-019 In READY, WR=1 with ADDR < DEPTH SHALL store IN_DATA at ADDR on that edge.
- REQ-020 In READY, RD=1 SHALL load OUT_DATA and set OUT_VALID=1 on that edge, giving 1-cycle latency.
- REQ-021 OUT_VALID SHALL return to 0 on the next edge unless RD stays 1, so back-to-back reads give one word per cycle.
- REQ-022 OUT_DATA SHALL hold its last value when no read is accepted.
- REQ-023 RD=1 and WR=1 on different in-range addresses SHALL both complete on the same edge.
- REQ-024 RD=1 and WR=1 on the same address SHALL always complete the write; the read data follows REQ-031/REQ-032.
- REQ-025 A request with ADDR >= DEPTH SHALL drop the write, return 0 on OUT_DATA for a read with OUT_VALID=1, and pulse ADDR_ERR for one cycle.
- REQ-026 ADDR_ERR SHALL pulse once per edge even if RD and WR are both out of range.
- REQ-027 Memory contents SHALL be unchanged by RD alone.

Reset
- REQ-028 While RESET=0 at an edge, the block SHALL set OUT_DATA=0, OUT_VALID=0, ADDR_ERR=0, BUSY=1, state=RST and clear-counter=0.
- REQ-029 RESET=0 during CLEAR or READY SHALL abort any in-flight operation; after release, CLEAR SHALL restart from address 0.
- REQ-030 After CLEAR completes, every location SHALL read 0.

Configuration
- REQ-031 With macro DMEM_WR_FWD_EN defined, a same-address RD and WR in one cycle SHALL return IN_DATA (new data) on OUT_DATA.
- REQ-032 With DMEM_WR_FWD_EN undefined, a same-address RD and WR in one cycle SHALL return the pre-write contents (old data).

Verification
- REQ-033 Bench SHALL check: RESET=0 for 3 edges, then release -> BUSY=1 for exactly DEPTH edges (2048 at default), then 0; a read of address 5 then gives OUT_DATA=0.
- REQ-034 Bench SHALL check: WR ADDR=1 IN_DATA=2, next cycle RD ADDR=1 -> OUT_DATA=2 and OUT_VALID=1 one edge after RD; OUT_VALID=0 on the following edge.
- REQ-035 Bench SHALL check: with location 2=4, RD and WR ADDR=2 IN_DATA=9 together -> OUT_DATA=9 with DMEM_WR_FWD_EN, else 4; a later read gives 9 in both builds.
- REQ-036 Bench SHALL check: DEPTH=1000, WR ADDR=1500 IN_DATA=7 -> ADDR_ERR pulses; a read of 1500 gives OUT_DATA=0 with ADDR_ERR=1; address 476 (1500 mod 1024) is unchanged.
- REQ-037 Bench SHALL check: RESET=0 midway through CLEAR at count 100 -> after release, BUSY stays high for a full DEPTH edges from address 0.
- REQ-038 Bench SHALL check: RD held high over addresses 0..3 holding 10,11,12,13 -> OUT_DATA 10,11,12,13 on consecutive edges with OUT_VALID continuously 1.
